pipe_reg_skid: RTL and testbench
================================

Name: pipe_reg_skid

Overview:
- Parametrised pipeline register stage with valid/ready handshake and a 2-entry skid buffer.
- Successor to the single-bit enable/load flop. Adds:
  - configurable width;
  - configurable reset/flush value;
  - synchronous load injection (bubble or NOP insertion);
  - flush;
  - backpressure without combinational ready paths.
- Placed between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) so hazard and branch logic can stall, squash or inject without breaking timing.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into data registers on arst and flush.

Ports:
- clk  in  1  rising-edge clock.
- arst  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held entries this cycle.
- load  in  1  inject load_data as the single held entry.
- load_data  in  WIDTH  injected payload (e.g. NOP instruction word).
- in_valid  in  1  upstream has data.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage can accept.
- out_valid  out  1  stage presents data.
- out_data  out  WIDTH  presented payload.
- out_ready  in  1  downstream accepts.
- occupancy  out  2  entries held (0..2).
- drop_pulse  out  1  one-cycle pulse: an upstream transfer was discarded by flush/load.

Behaviour:
- Registers:
  - main_q, skid_q: WIDTH each.
  - state: EMPTY, FULL or SKID.
- Combinational outputs, all decoded from registers only:
  - out_data = main_q.
  - out_valid = (state != EMPTY).
  - in_ready = (state != SKID). No combinational path from out_ready or in_valid.
  - occupancy: EMPTY=0, FULL=1, SKID=2.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Priority per clock edge: arst > flush > load > normal.
- arst:
  - state=EMPTY; main_q=skid_q=RESET_VAL; drop_pulse=0.
  - After reset: out_valid=0, in_ready=1, occupancy=0.
- flush (arst=0):
  - state=EMPTY; main_q=skid_q=RESET_VAL.
  - Any in_fire this cycle is discarded; drop_pulse=1 next cycle iff in_fire.
  - out_fire this cycle still counts as consumed by downstream.
- load (arst=0, flush=0):
  - state=FULL; main_q=load_data; skid_q=RESET_VAL.
  - Any in_fire is discarded; drop_pulse=1 next cycle iff in_fire.
  - flush and load together: flush wins.
- Normal transitions:
  - EMPTY: in_fire → FULL, main_q=in_data. Otherwise hold.
  - FULL, out_fire & in_fire → FULL, main_q=in_data (full throughput).
  - FULL, out_fire & !in_fire → EMPTY.
  - FULL, !out_fire & in_fire → SKID, skid_q=in_data.
  - FULL, neither → hold.
  - SKID (in_ready=0): out_fire → FULL, main_q=skid_q. Otherwise hold.
  - SKID: in_valid ignored; upstream must hold its data.
- Timing:
  - Latency in_fire → out_valid: 1 cycle.
  - Sustained throughput: 1 transfer/cycle.
  - Ordering is strictly FIFO; no entry duplicated or lost except via flush/load.
- Unused data registers keep their last value, except on arst and flush. Verification compares out_data only while out_valid=1.
- drop_pulse is registered and cleared on any cycle without a drop.
- Reset mid-operation: arst overrides any pending SKID/FULL contents in one cycle and produces no drop_pulse.

Decomposition:
- Shared package pipe_pkg:
  - state enum {EMPTY=2'd0, FULL=2'd1, SKID=2'd2};
  - localparam MIPS_NOP = 32'h0000_0000, for load_data/RESET_VAL at instantiation.
- Optional sub-module pipe_skid_ctrl:
  - contains the state machine plus in_ready/out_valid/occupancy/drop_pulse logic;
  - outputs write enables for main_q/skid_q and a main-source select.
  - Top level holds the WIDTH-wide data registers.

Test Plan:
- Reset: arst=1 for 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF → out_valid=0, in_ready=1, occupancy=0, drop_pulse=0.
- Streaming: out_ready=1, feed 0x1,0x2,0x3 on consecutive cycles → out_data shows 0x1,0x2,0x3 on the following cycles; occupancy stays ≤1.
- Backpressure: deliver 0xA; drop out_ready; offer 0xB → occupancy=2, in_ready=0. Offer 0xC, then raise out_ready → outputs 0xA, 0xB, then 0xC after in_ready returns; 0xC is not lost.
- Flush in SKID: occupancy=2, flush=1 with in_valid=1 → next cycle occupancy=0, out_valid=0, drop_pulse=1 for exactly 1 cycle.
- Load: load=1, load_data=MIPS_NOP while FULL with 0x55 → out_data=0x0, occupancy=1. flush+load together → EMPTY.
- Randomised in_valid/out_ready for 10k cycles vs scoreboard → in-order, no loss, no duplication; in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline register stage: controller states, the
// main-register source select and the MIPS NOP word used for bubble injection.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

   typedef enum logic [1:0] {
      SRC_IN   = 2'd0,
      SRC_SKID = 2'd1,
      SRC_LOAD = 2'd2,
      SRC_RST  = 2'd3
   } main_src_e;

   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

   function automatic logic [1:0] occ_of(input pipe_state_e s);
      case (s)
         FULL:    occ_of = 2'd1;
         SKID:    occ_of = 2'd2;
         default: occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Control for the skid stage: state machine, handshake flags, drop pulse and
// the write enables / source select that steer the top-level data registers.
module pipe_skid_ctrl
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        arst,
   input  logic        flush,
   input  logic        load,
   input  logic        in_valid,
   input  logic        out_ready,
   output pipe_state_e state_q,
   output logic        in_ready,
   output logic        out_valid,
   output logic        drop_pulse,
   output logic        main_we,
   output main_src_e   main_src,
   output logic        skid_we,
   output logic        skid_clr
);

   // Handshake: a transfer happens on an edge where valid and ready are both
   // high; ready depends only on state, so upstream must hold data while
   // valid is high and ready is low.
   logic in_fire;
   logic out_fire;

   assign in_ready  = (state_q != SKID);
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q    <= EMPTY;
         drop_pulse <= 1'b0;
      end else if (flush) begin
         state_q    <= EMPTY;
         drop_pulse <= in_fire;
      end else if (load) begin
         state_q    <= FULL;
         drop_pulse <= in_fire;
      end else begin
         drop_pulse <= 1'b0;
         case (state_q)
            EMPTY: if (in_fire) state_q <= FULL;
            FULL: begin
               if (out_fire && !in_fire)      state_q <= EMPTY;
               else if (!out_fire && in_fire) state_q <= SKID;
            end
            SKID: if (out_fire) state_q <= FULL;
            default: state_q <= EMPTY;
         endcase
      end
   end

   always_comb begin
      main_we  = 1'b0;
      main_src = SRC_IN;
      skid_we  = 1'b0;
      skid_clr = 1'b0;
      if (arst || flush) begin
         main_we  = 1'b1;
         main_src = SRC_RST;
         skid_we  = 1'b1;
         skid_clr = 1'b1;
      end else if (load) begin
         main_we  = 1'b1;
         main_src = SRC_LOAD;
         skid_we  = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state_q)
            EMPTY: main_we = in_fire;
            FULL: begin
               main_we = in_fire & out_fire;
               skid_we = in_fire & ~out_fire;
            end
            SKID: begin
               main_we  = out_fire;
               main_src = SRC_SKID;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline register stage with valid/ready handshake and a two-entry skid
// buffer; supports flush, bubble/NOP injection and registered-only ready.
module pipe_reg_skid
   import pipe_pkg::*;
#(
   parameter int                 WIDTH     = 32,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             flush,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy,
   output logic             drop_pulse
);

   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   pipe_state_e      state_q;
   logic             main_we;
   main_src_e        main_src;
   logic             skid_we;
   logic             skid_clr;

   pipe_skid_ctrl u_ctrl (
      .clk        (clk),
      .arst       (arst),
      .flush      (flush),
      .load       (load),
      .in_valid   (in_valid),
      .out_ready  (out_ready),
      .state_q    (state_q),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .drop_pulse (drop_pulse),
      .main_we    (main_we),
      .main_src   (main_src),
      .skid_we    (skid_we),
      .skid_clr   (skid_clr)
   );

   // Reset is folded into the controller's enables, so data regs see no arst.
   always_ff @(posedge clk) begin
      if (main_we) begin
         case (main_src)
            SRC_IN:   main_q <= in_data;
            SRC_SKID: main_q <= skid_q;
            SRC_LOAD: main_q <= load_data;
            default:  main_q <= RESET_VAL;
         endcase
      end
      if (skid_we) skid_q <= skid_clr ? RESET_VAL : in_data;
   end

   assign out_data  = main_q;
   assign occupancy = occ_of(state_q);

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed vector table, hand-written reset/backpressure sequences and a
// randomised scoreboard run for the pipeline skid stage.
module tb_pipe_reg_skid;
   import pipe_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         arst, flush, load, in_valid, out_ready;
   logic [W-1:0] load_data, in_data;
   logic         in_ready, out_valid, drop_pulse;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   pipe_reg_skid #(.WIDTH(W), .RESET_VAL(MIPS_NOP)) dut (
      .clk        (clk),
      .arst       (arst),
      .flush      (flush),
      .load       (load),
      .load_data  (load_data),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .occupancy  (occupancy),
      .drop_pulse (drop_pulse)
   );

   typedef struct {
      logic         fl;
      logic         ld;
      logic [W-1:0] ld_data;
      logic         iv;
      logic [W-1:0] id;
      logic         ordy;
      logic         e_ov;
      logic [W-1:0] e_od;
      logic         e_ir;
      logic [1:0]   e_occ;
      logic         e_drop;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs[NV];

   function automatic vec_t mk(logic fl, logic ld, logic [W-1:0] ldd, logic iv,
                               logic [W-1:0] id, logic ordy, logic e_ov,
                               logic [W-1:0] e_od, logic e_ir, logic [1:0] e_occ,
                               logic e_drop);
      vec_t v;
      v.fl = fl; v.ld = ld; v.ld_data = ldd; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ; v.e_drop = e_drop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic e_ov, input logic [W-1:0] e_od,
                           input logic e_ir, input logic [1:0] e_occ, input logic e_drop);
      chk({tag, ".out_valid"}, W'(out_valid), W'(e_ov));
      chk({tag, ".in_ready"}, W'(in_ready), W'(e_ir));
      chk({tag, ".occupancy"}, W'(occupancy), W'(e_occ));
      chk({tag, ".drop_pulse"}, W'(drop_pulse), W'(e_drop));
      if (e_ov) chk({tag, ".out_data"}, out_data, e_od);
   endtask

   task automatic drive(input logic fl, input logic ld, input logic [W-1:0] ldd,
                        input logic iv, input logic [W-1:0] id, input logic ordy);
      flush = fl; load = ld; load_data = ldd; in_valid = iv; in_data = id; out_ready = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                 fl ld ld_data  iv id       ordy ov od       ir occ drop
      vecs[0]  = mk(0, 0, 32'h0,  1, 32'h1,  1,   1, 32'h1,  1, 2'd1, 0); // streaming
      vecs[1]  = mk(0, 0, 32'h0,  1, 32'h2,  1,   1, 32'h2,  1, 2'd1, 0);
      vecs[2]  = mk(0, 0, 32'h0,  1, 32'h3,  1,   1, 32'h3,  1, 2'd1, 0);
      vecs[3]  = mk(0, 0, 32'h0,  0, 32'h0,  1,   0, 32'h0,  1, 2'd0, 0);
      vecs[4]  = mk(0, 0, 32'h0,  1, 32'hA,  0,   1, 32'hA,  1, 2'd1, 0); // backpressure
      vecs[5]  = mk(0, 0, 32'h0,  1, 32'hB,  0,   1, 32'hA,  0, 2'd2, 0);
      vecs[6]  = mk(0, 0, 32'h0,  1, 32'hC,  0,   1, 32'hA,  0, 2'd2, 0);
      vecs[7]  = mk(0, 0, 32'h0,  1, 32'hC,  1,   1, 32'hB,  1, 2'd1, 0);
      vecs[8]  = mk(0, 0, 32'h0,  1, 32'hC,  0,   1, 32'hB,  0, 2'd2, 0);
      vecs[9]  = mk(0, 0, 32'h0,  0, 32'h0,  1,   1, 32'hC,  1, 2'd1, 0);
      vecs[10] = mk(0, 0, 32'h0,  0, 32'h0,  1,   0, 32'h0,  1, 2'd0, 0);
      vecs[11] = mk(0, 0, 32'h0,  1, 32'h11, 0,   1, 32'h11, 1, 2'd1, 0); // flush in SKID
      vecs[12] = mk(0, 0, 32'h0,  1, 32'h22, 0,   1, 32'h11, 0, 2'd2, 0);
      vecs[13] = mk(1, 0, 32'h0,  1, 32'h33, 0,   0, 32'h0,  1, 2'd0, 0); // in_ready=0: no fire
      vecs[14] = mk(0, 0, 32'h0,  1, 32'h44, 0,   1, 32'h44, 1, 2'd1, 0); // flush in FULL
      vecs[15] = mk(1, 0, 32'h0,  1, 32'h55, 0,   0, 32'h0,  1, 2'd0, 1);
      vecs[16] = mk(0, 0, 32'h0,  0, 32'h0,  0,   0, 32'h0,  1, 2'd0, 0);
      vecs[17] = mk(0, 0, 32'h0,  1, 32'h55, 0,   1, 32'h55, 1, 2'd1, 0); // load NOP
      vecs[18] = mk(0, 1, MIPS_NOP, 0, 32'h0, 0,  1, 32'h0,  1, 2'd1, 0);
      vecs[19] = mk(0, 0, 32'h0,  1, 32'h66, 0,   1, 32'h0,  0, 2'd2, 0);
      vecs[20] = mk(0, 1, 32'h77, 1, 32'h68, 0,   1, 32'h77, 1, 2'd1, 0); // load from SKID
      vecs[21] = mk(0, 1, 32'h88, 1, 32'h99, 1,   1, 32'h88, 1, 2'd1, 1); // load drops in_fire
      vecs[22] = mk(1, 1, 32'h12, 0, 32'h0,  0,   0, 32'h0,  1, 2'd0, 0); // flush beats load
      vecs[23] = mk(0, 0, 32'h0,  0, 32'h0,  1,   0, 32'h0,  1, 2'd0, 0);

      // reset with upstream pushing
      arst = 1'b1;
      drive(0, 0, 32'h0, 1, 32'hDEAD_BEEF, 0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk_outs($sformatf("reset%0d", i), 0, 32'h0, 1, 2'd0, 0);
      end
      arst = 1'b0;
      drive(0, 0, 32'h0, 0, 32'h0, 0);
      step();
      chk_outs("post_reset", 0, 32'h0, 1, 2'd0, 0);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].fl, vecs[i].ld, vecs[i].ld_data, vecs[i].iv, vecs[i].id, vecs[i].ordy);
         step();
         chk_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir,
                  vecs[i].e_occ, vecs[i].e_drop);
      end

      // ready must not follow out_ready within a cycle; then reset from SKID
      drive(0, 0, 32'h0, 1, 32'hA1, 0);
      step();
      drive(0, 0, 32'h0, 1, 32'hA2, 0);
      step();
      chk_outs("midrst_skid", 1, 32'hA1, 0, 2'd2, 0);
      out_ready = 1'b1;
      #1;
      chk("comb_ready", W'(in_ready), W'(1'b0));
      out_ready = 1'b0;
      arst = 1'b1;
      drive(0, 0, 32'h0, 1, 32'hA3, 1);
      step();
      chk_outs("midrst", 0, 32'h0, 1, 2'd0, 0);
      arst = 1'b0;
      drive(0, 0, 32'h0, 1, 32'hB1, 0);
      step();
      chk_outs("midrst_after", 1, 32'hB1, 1, 2'd1, 0);
      drive(0, 0, 32'h0, 0, 32'h0, 1);
      step();
      chk_outs("midrst_drain", 0, 32'h0, 1, 2'd0, 0);

      // randomised traffic against a FIFO scoreboard
      begin
         logic in_f, out_f, fired_last;
         fired_last = 1'b1;
         exp_q.delete();
         drive(0, 0, 32'h0, 0, 32'h0, 0);
         for (int cyc = 0; cyc < 10000; cyc++) begin
            chk("rnd.occupancy", W'(occupancy), W'(exp_q.size()));
            chk("rnd.out_valid", W'(out_valid), W'(exp_q.size() != 0));
            chk("rnd.in_ready", W'(in_ready), W'(exp_q.size() < 2));
            if (exp_q.size() != 0 && out_valid) chk("rnd.out_data", out_data, exp_q[0]);
            if (!(in_valid && !fired_last)) begin
               in_valid = ($urandom_range(0, 2) != 0);
               in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            in_f  = in_valid & in_ready;
            out_f = out_valid & out_ready;
            @(posedge clk);
            if (out_f) begin
               if (exp_q.size() == 0) chk("rnd.underflow", 32'h1, 32'h0);
               else void'(exp_q.pop_front());
            end
            if (in_f) exp_q.push_back(in_data);
            fired_last = in_f;
            #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
